// File: rtl/unpadder_pkg.sv
// Shared constants and types for the Keccak unpadder.
//   RATE_BITS/WORD_BITS/RATE_WORDS/RATE_BYTES : rate-block geometry
//   PAD_FIRST    : value of the first pad byte (pad10*1 opening bit)
//   PAD_LAST_BIT : bit index of the closing pad bit inside the block
//   state_e      : unpadder FSM states
//   word_mask    : keep-mask for the top n bytes of a 32-bit word
package unpadder_pkg;

  localparam int unsigned RATE_BITS    = 576;
  localparam int unsigned WORD_BITS    = 32;
  localparam int unsigned RATE_WORDS   = 18;
  localparam int unsigned RATE_BYTES   = 72;
  localparam logic [7:0]  PAD_FIRST    = 8'h01;
  localparam int unsigned PAD_LAST_BIT = 7;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Byte 0 is the MSB byte, so n valid bytes keeps the top n bytes.
  function automatic logic [WORD_BITS-1:0] word_mask(logic [1:0] n);
    logic [WORD_BITS-1:0] m;
    unique case (n)
      2'd0:    m = 32'h0000_0000;
      2'd1:    m = 32'hFF00_0000;
      2'd2:    m = 32'hFFFF_0000;
      default: m = 32'hFFFF_FF00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/unpadder_if.sv
// Block-in / word-out bundle for the unpadder.
//   in_block/in_valid/in_last/in_ready : padded rate-block input handshake
//   out/out_valid/out_ready/out_last/out_byte_num : message word output handshake
//   pad_error : one-cycle malformed-padding pulse
// slave  = unpadder view, master = block source / word sink view.
interface unpadder_if;
  import unpadder_pkg::*;

  logic [RATE_BITS-1:0] in_block;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [WORD_BITS-1:0] out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [1:0]           out_byte_num;
  logic                 pad_error;

  modport slave (
    input  in_block, in_valid, in_last, out_ready,
    output in_ready, out, out_valid, out_last, out_byte_num, pad_error
  );

  modport master (
    output in_block, in_valid, in_last, out_ready,
    input  in_ready, out, out_valid, out_last, out_byte_num, pad_error
  );

endinterface

// File: rtl/unpad_locate.sv
// Combinational pad locator for a final rate block.
//   in_block_i : padded block, byte b = in_block_i[575-8b -: 8]
//   pad_idx_o  : index of the highest nonzero byte (byte 71 seen without its closing bit)
//   pad_ok_o   : closing bit set, a nonzero byte exists and that byte is PAD_FIRST
module unpad_locate
  import unpadder_pkg::*;
(
  input  logic [RATE_BITS-1:0] in_block_i,
  output logic [6:0]           pad_idx_o,
  output logic                 pad_ok_o
);

  logic       found;
  logic [7:0] top_byte;
  logic [7:0] cur;

  // Ascending scan, later hits overwrite earlier ones: result is the highest nonzero byte.
  always_comb begin
    pad_idx_o = '0;
    found     = 1'b0;
    top_byte  = '0;
    cur       = '0;
    for (int unsigned b = 0; b < RATE_BYTES; b++) begin
      cur = in_block_i[RATE_BITS-1-8*b -: 8];
      // Byte 71 carries the closing bit; only its remaining bits may hold the opening 0x01.
      if (b == RATE_BYTES - 1) cur = cur & 8'h7F;
      if (cur != 8'h00) begin
        found     = 1'b1;
        pad_idx_o = 7'(b);
        top_byte  = cur;
      end
    end
    pad_ok_o = in_block_i[PAD_LAST_BIT] & found & (top_byte == PAD_FIRST);
  end

endmodule

// File: rtl/unpadder.sv
// Keccak unpadder: accepts 576-bit rate blocks and streams them as 32-bit words.
// On a final block the pad10*1 bytes are stripped and the last word is flagged with
// out_last/out_byte_num; malformed padding pulses pad_error and emits nothing.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : unpadder_if.slave (block input, word output, pad_error)
module unpadder
  import unpadder_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  unpadder_if.slave  bus
);

  state_e               state_q, state_d;
  logic [RATE_BITS-1:0] shift_q, shift_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [4:0]           last_idx_q, last_idx_d;
  logic [1:0]           byte_num_q, byte_num_d;
  logic                 final_q, final_d;
  logic                 pad_err_q, pad_err_d;

  logic [6:0]           pad_idx;
  logic                 pad_ok;
  logic                 in_ready;
  logic                 accept;
  logic                 out_valid;
  logic                 out_last;
  logic                 at_last;
  logic                 out_hs;
  logic [WORD_BITS-1:0] out_word;

  unpad_locate u_locate (
    .in_block_i (bus.in_block),
    .pad_idx_o  (pad_idx),
    .pad_ok_o   (pad_ok)
  );

  assign in_ready  = (state_q == StIdle) & reset_n;
  assign accept    = bus.in_valid & in_ready;
  assign out_valid = (state_q == StSend);
  assign at_last   = (cnt_q == last_idx_q);
  assign out_last  = out_valid & final_q & at_last;
  assign out_hs    = out_valid & bus.out_ready;

  always_comb begin
    out_word = '0;
    if (out_valid) begin
      out_word = shift_q[RATE_BITS-1 -: WORD_BITS];
      if (out_last) out_word = out_word & word_mask(byte_num_q);
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out          = out_word;
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;
  assign bus.out_byte_num = out_last ? byte_num_q : 2'd0;
  assign bus.pad_error    = pad_err_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    byte_num_d = byte_num_q;
    final_d    = final_q;
    pad_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.in_last && !pad_ok) begin
            pad_err_d = 1'b1;
          end else begin
            state_d    = StSend;
            shift_d    = bus.in_block;
            cnt_d      = '0;
            final_d    = bus.in_last;
            last_idx_d = bus.in_last ? pad_idx[6:2] : 5'(RATE_WORDS - 1);
            byte_num_d = bus.in_last ? pad_idx[1:0] : 2'd0;
          end
        end
      end
      StSend: begin
        if (out_hs) begin
          if (at_last) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            shift_d = shift_q << WORD_BITS;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      byte_num_q <= '0;
      final_q    <= 1'b0;
      pad_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      byte_num_q <= byte_num_d;
      final_q    <= final_d;
      pad_err_q  <= pad_err_d;
    end
  end

endmodule

// File: tb/tb_unpadder.sv
module tb_unpadder;
  import unpadder_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  unpadder_if bus ();

  unpadder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [575:0] blk;
    logic         last;
    int           n_words;
    logic [31:0]  last_word;
    logic [1:0]   byte_num;
    logic         err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [575:0] b, input int k);
    return b[575-32*k -: 32];
  endfunction

  function automatic logic [575:0] set_word(input logic [575:0] b, input int k,
                                            input logic [31:0] w);
    logic [575:0] r;
    r = b;
    r[575-32*k -: 32] = w;
    return r;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp;
    logic        is_last;
    bus.in_block  = v.blk;
    bus.in_last   = v.last;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check($sformatf("%s in_ready_pre", tag), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (v.err) begin
      check($sformatf("%s pad_error", tag), 32'(bus.pad_error), 32'd1);
      check($sformatf("%s no_out_valid", tag), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s in_ready_err", tag), 32'(bus.in_ready), 32'd1);
    end else begin
      for (int k = 0; k < v.n_words; k++) begin
        is_last = (k == v.n_words - 1);
        exp = is_last ? v.last_word : word_of(v.blk, k);
        check($sformatf("%s w%0d valid", tag, k), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s w%0d data", tag, k), bus.out, exp);
        check($sformatf("%s w%0d last", tag, k), 32'(bus.out_last), 32'(is_last && v.last));
        check($sformatf("%s w%0d byte_num", tag, k), 32'(bus.out_byte_num),
              (is_last && v.last) ? 32'(v.byte_num) : 32'd0);
        check($sformatf("%s w%0d in_ready", tag, k), 32'(bus.in_ready), 32'd0);
        check($sformatf("%s w%0d pad_error", tag, k), 32'(bus.pad_error), 32'd0);
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("%s end out_valid", tag), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s end in_ready", tag), 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [575:0] b;
    vec_t v6;

    bus.in_block  = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // 0: non-final block, words 0x0..0x11
    b = '0;
    for (int k = 0; k < 18; k++) b = set_word(b, k, 32'(k));
    vecs[0] = '{blk: b, last: 1'b0, n_words: 18, last_word: 32'h0000_0011,
                byte_num: 2'd0, err: 1'b0};
    // 1: pad opens at byte 14, 4 words, last 0xAABB0000, byte_num 2
    b = '0;
    b = set_word(b, 0, 32'hDEAD_0000);
    b = set_word(b, 1, 32'hDEAD_0001);
    b = set_word(b, 2, 32'hDEAD_0002);
    b = set_word(b, 3, 32'hAABB_0100);
    b = set_word(b, 17, 32'h0000_0080);
    vecs[1] = '{blk: b, last: 1'b1, n_words: 4, last_word: 32'hAABB_0000,
                byte_num: 2'd2, err: 1'b0};
    // 2: combined 0x81 in byte 71, full 18 words, byte_num 3
    b = '0;
    for (int k = 0; k < 17; k++) b = set_word(b, k, 32'h5000_0000 + 32'(k));
    b = set_word(b, 17, 32'h1122_3381);
    vecs[2] = '{blk: b, last: 1'b1, n_words: 18, last_word: 32'h1122_3300,
                byte_num: 2'd3, err: 1'b0};
    // 3: closing bit clear -> error
    b = '0;
    for (int k = 0; k < 17; k++) b = set_word(b, k, 32'h7000_0000 + 32'(k));
    vecs[3] = '{blk: b, last: 1'b1, n_words: 0, last_word: 32'h0,
                byte_num: 2'd0, err: 1'b1};
    // 4: empty message, pad in byte 0 -> one zero word, byte_num 0
    b = '0;
    b = set_word(b, 0, 32'h0100_0000);
    b = set_word(b, 17, 32'h0000_0080);
    vecs[4] = '{blk: b, last: 1'b1, n_words: 1, last_word: 32'h0000_0000,
                byte_num: 2'd0, err: 1'b1 & 1'b0};
    // 5: top byte 0x02 (byte 71 = 0x82) -> error
    b = '0;
    b = set_word(b, 17, 32'h0000_0082);
    vecs[5] = '{blk: b, last: 1'b1, n_words: 0, last_word: 32'h0,
                byte_num: 2'd0, err: 1'b1};
    // 6: closing bit only, no nonzero byte -> error
    b = '0;
    b = set_word(b, 17, 32'h0000_0080);
    vecs[6] = '{blk: b, last: 1'b1, n_words: 0, last_word: 32'h0,
                byte_num: 2'd0, err: 1'b1};

    // Reset state
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out", bus.out, 32'd0);
    check("rst out_last", 32'(bus.out_last), 32'd0);
    check("rst byte_num", 32'(bus.out_byte_num), 32'd0);
    check("rst pad_error", 32'(bus.pad_error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Stall at word 7, then reset at word 10.
    b = '0;
    for (int k = 0; k < 18; k++) b = set_word(b, k, 32'h0000_0100 + 32'(k));
    v6 = '{blk: b, last: 1'b0, n_words: 18, last_word: 32'h0000_0111,
           byte_num: 2'd0, err: 1'b0};
    bus.in_block  = v6.blk;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("stall w%0d valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall w%0d data", k), bus.out, 32'h0000_0100 + 32'(k));
      if (k == 7) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk);
          @(negedge clk);
          check($sformatf("hold%0d data", s), bus.out, 32'h0000_0107);
          check($sformatf("hold%0d valid", s), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
      end
      if (k == 10) begin
        reset_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("relrst in_ready", 32'(bus.in_ready), 32'd1);
        check("relrst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    run_vec(vecs[1], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
